// File: rtl/al_copy_pkg.sv
// Shared types for the AL copy master: FSM state encoding and AL width helpers.
package al_copy_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } copy_state_e;

   // AL data bus width follows the byte-lane count: 8 bits per byte, 2**data_bits bytes.
   function automatic int unsigned al_data_width(input int unsigned data_bits);
      return 8 << data_bits;
   endfunction

endpackage

// File: rtl/al_copy_fifo.sv
// First-word fall-through synchronous FIFO holding AL read data until it can be written back.
module al_copy_fifo
#(
   parameter int WIDTH      = 32,
   parameter int DEPTH_BITS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_i,
   input  logic [WIDTH-1:0]      push_data_i,
   input  logic                  pop_i,
   output logic [WIDTH-1:0]      head_o,
   output logic                  empty_o,
   output logic [DEPTH_BITS:0]   count_o
);

   localparam int DEPTH = 1 << DEPTH_BITS;
   localparam logic [DEPTH_BITS-1:0] PTR_ONE = DEPTH_BITS'(1);
   localparam logic [DEPTH_BITS:0]   CNT_ONE = (DEPTH_BITS + 1)'(1);

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_BITS:0]   count_q, count_d;
   logic                  full;
   logic                  do_push;
   logic                  do_pop;

   assign empty_o = (count_q == '0);
   assign full    = (count_q == (DEPTH_BITS + 1)'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   // A push into a full FIFO is still accepted when the head leaves in the same cycle.
   assign do_push = push_i && (!full || do_pop);
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/al_copy_master.sv
// AL-bus initiator copying cmd_len+1 words from cmd_src to cmd_dst. Reads are credit-limited
// by FIFO depth so read data is always accepted; writes drain the FIFO concurrently.
module al_copy_master
   import al_copy_pkg::*;
#(
   parameter int          ADDR_WIDTH = 12,
   parameter int          DATA_BITS  = 2,
   parameter int          DATA_WIDTH = al_data_width(DATA_BITS),
   parameter int          ID_WIDTH   = 1,
   parameter int unsigned AL_ID      = 0,
   parameter int          LEN_WIDTH  = 10,
   parameter int          FIFO_BITS  = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [ADDR_WIDTH-DATA_BITS-1:0] cmd_src,
   input  logic [ADDR_WIDTH-DATA_BITS-1:0] cmd_dst,
   input  logic [LEN_WIDTH-1:0]            cmd_len,
   input  logic                           cmd_valid,
   output logic                           cmd_ready,
   output logic                           done,
   output logic                           id_err,
   output logic [ADDR_WIDTH-DATA_BITS-1:0] m_al_araddr,
   output logic                           m_al_arvalid,
   output logic [ID_WIDTH-1:0]             m_al_arid,
   input  logic                           m_al_arready,
   input  logic [DATA_WIDTH-1:0]           m_al_rdata,
   input  logic                           m_al_rvalid,
   input  logic [ID_WIDTH-1:0]             m_al_rid,
   output logic                           m_al_rready,
   output logic [ADDR_WIDTH-DATA_BITS-1:0] m_al_waddr,
   output logic [DATA_WIDTH-1:0]           m_al_wdata,
   output logic                           m_al_wvalid,
   input  logic                           m_al_wready,
   output logic [1:0]                     dbg_state
);

   localparam int WA    = ADDR_WIDTH - DATA_BITS;
   localparam int CW    = FIFO_BITS + 1;
   localparam int RW    = LEN_WIDTH + 1;
   localparam int DEPTH = 1 << FIFO_BITS;
   localparam logic [ID_WIDTH-1:0] AL_ID_C = AL_ID[ID_WIDTH-1:0];

   copy_state_e     state_q, state_d;
   logic [WA-1:0]   src_q, src_d;
   logic [WA-1:0]   dst_q, dst_d;
   logic [RW-1:0]   rd_left_q, rd_left_d;
   logic [RW-1:0]   wr_left_q, wr_left_d;
   logic [CW-1:0]   inflight_q, inflight_d;
   logic            done_q, done_d;
   logic            id_err_q, id_err_d;

   logic [CW-1:0]         fifo_count;
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_head;
   logic [CW:0]           credit_used;
   logic                  ar_fire;
   logic                  r_push;
   logic                  r_drop;
   logic                  w_fire;

   // Outstanding reads plus buffered words can never exceed the FIFO depth,
   // so every returning beat has a slot and rready can stay high.
   assign credit_used  = {1'b0, inflight_q} + {1'b0, fifo_count};
   assign m_al_arvalid = (state_q == ST_RUN) && (rd_left_q != '0)
                         && (credit_used < (CW + 1)'(DEPTH));
   assign ar_fire      = m_al_arvalid && m_al_arready;
   assign r_push       = m_al_rvalid && (inflight_q != '0) && (state_q != ST_IDLE);
   assign r_drop       = m_al_rvalid && !r_push;
   assign m_al_wvalid  = !fifo_empty;
   assign w_fire       = m_al_wvalid && m_al_wready;

   assign m_al_araddr = src_q;
   assign m_al_arid   = AL_ID_C;
   assign m_al_rready = 1'b1;
   assign m_al_waddr  = dst_q;
   assign m_al_wdata  = fifo_head;
   assign cmd_ready   = (state_q == ST_IDLE);
   assign done        = done_q;
   assign id_err      = id_err_q;
   assign dbg_state   = state_q;

   always_comb begin
      state_d    = state_q;
      src_d      = src_q;
      dst_d      = dst_q;
      rd_left_d  = rd_left_q;
      wr_left_d  = wr_left_q;
      inflight_d = inflight_q;
      done_d     = 1'b0;
      id_err_d   = id_err_q | r_drop | (m_al_rvalid && (m_al_rid != AL_ID_C));

      case ({ar_fire, r_push})
         2'b10:   inflight_d = inflight_q + CW'(1);
         2'b01:   inflight_d = inflight_q - CW'(1);
         default: inflight_d = inflight_q;
      endcase
      if (ar_fire) begin
         src_d     = src_q + WA'(1);
         rd_left_d = rd_left_q - RW'(1);
      end
      if (w_fire) begin
         dst_d     = dst_q + WA'(1);
         wr_left_d = wr_left_q - RW'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               src_d     = cmd_src;
               dst_d     = cmd_dst;
               rd_left_d = {1'b0, cmd_len} + RW'(1);
               wr_left_d = {1'b0, cmd_len} + RW'(1);
               state_d   = ST_RUN;
            end
         end
         ST_RUN: begin
            if (ar_fire && (rd_left_q == RW'(1))) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            // The last word can only be written once all reads are issued.
            if (w_fire && (wr_left_q == RW'(1))) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         src_q      <= '0;
         dst_q      <= '0;
         rd_left_q  <= '0;
         wr_left_q  <= '0;
         inflight_q <= '0;
         done_q     <= 1'b0;
         id_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         dst_q      <= dst_d;
         rd_left_q  <= rd_left_d;
         wr_left_q  <= wr_left_d;
         inflight_q <= inflight_d;
         done_q     <= done_d;
         id_err_q   <= id_err_d;
      end
   end

   al_copy_fifo #(
      .WIDTH      (DATA_WIDTH),
      .DEPTH_BITS (FIFO_BITS)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (r_push),
      .push_data_i (m_al_rdata),
      .pop_i       (w_fire),
      .head_o      (fifo_head),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

endmodule
